// File: rtl/game_mode_fsm_pkg.sv
// Shared game-mode definitions used by the mode FSM and the VGA enable decoder.
package game_mode_fsm_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MENU     = 2'd0;
    localparam mode_t MODE_REACTION = 2'd1;
    localparam mode_t MODE_CHIMP    = 2'd2;
    localparam mode_t MODE_RESULT   = 2'd3;

    function automatic mode_t game_for_cursor(input logic cursor);
        return cursor ? MODE_CHIMP : MODE_REACTION;
    endfunction

endpackage

// File: rtl/game_mode_fsm_key_press_detect.sv
// Rising-edge press detector: one press per 0->1 transition of a clean key level.
module key_press_detect (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic press
);

    logic prev_r;

    // History cleared in reset so a key held through reset release reads as a press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= key;
        end
    end

    assign press = key & ~prev_r;

endmodule

// File: rtl/game_mode_fsm.sv
// Top-level game mode sequencer: menu cursor, game entry/abort and timed result screen.
module game_mode_fsm
    import game_mode_fsm_pkg::*;
#(
    parameter int RESULT_CYCLES = 50_000_000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       iKeyUp,
    input  logic       iKeyDown,
    input  logic       iKeySelect,
    input  logic       iKeyBack,
    input  logic       iGameDone,
    output logic [1:0] oGameMode,
    output logic       oCursor,
    output logic       oStartPulse,
    output logic       oAbortPulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_CYCLES - 1);

    logic up_press_s;
    logic down_press_s;
    logic sel_press_s;
    logic back_press_s;

    key_press_detect u_up   (.clk(clk), .resetn(resetn), .key(iKeyUp),     .press(up_press_s));
    key_press_detect u_down (.clk(clk), .resetn(resetn), .key(iKeyDown),   .press(down_press_s));
    key_press_detect u_sel  (.clk(clk), .resetn(resetn), .key(iKeySelect), .press(sel_press_s));
    key_press_detect u_back (.clk(clk), .resetn(resetn), .key(iKeyBack),   .press(back_press_s));

    mode_t            state_r;
    logic             cursor_r;
    logic             start_r;
    logic             abort_r;
    logic [CNT_W-1:0] cnt_r;

    mode_t            state_s;
    logic             cursor_s;
    logic             start_s;
    logic             abort_s;
    logic [CNT_W-1:0] cnt_s;

    // Next-state decode; Back outranks Select, which outranks cursor movement.
    always_comb begin
        state_s  = state_r;
        cursor_s = cursor_r;
        start_s  = 1'b0;
        abort_s  = 1'b0;
        cnt_s    = cnt_r;
        case (state_r)
            MODE_MENU: begin
                if (sel_press_s) begin
                    state_s = game_for_cursor(cursor_r);
                    start_s = 1'b1;
                end else if (up_press_s ^ down_press_s) begin
                    cursor_s = ~cursor_r;
                end else begin
                    cursor_s = cursor_r;
                end
            end
            MODE_REACTION, MODE_CHIMP: begin
                if (back_press_s) begin
                    state_s = MODE_MENU;
                    abort_s = 1'b1;
                end else if (iGameDone) begin
                    state_s = MODE_RESULT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            MODE_RESULT: begin
                if (sel_press_s || back_press_s || (cnt_r == CNT_LAST)) begin
                    state_s = MODE_MENU;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = MODE_MENU;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, cursor, counter and pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= MODE_MENU;
            cursor_r <= 1'b0;
            start_r  <= 1'b0;
            abort_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cursor_r <= cursor_s;
            start_r  <= start_s;
            abort_r  <= abort_s;
            cnt_r    <= cnt_s;
        end
    end

    assign oGameMode   = state_r;
    assign oCursor     = cursor_r;
    assign oStartPulse = start_r;
    assign oAbortPulse = abort_r;

endmodule

// File: tb/tb_game_mode_fsm.sv
// Randomized bench for game_mode_fsm against a cycle-indexed behavioural model.
module tb_game_mode_fsm;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       iKeyUp = 1'b0;
    logic       iKeyDown = 1'b0;
    logic       iKeySelect = 1'b0;
    logic       iKeyBack = 1'b0;
    logic       iGameDone = 1'b0;
    logic [1:0] oGameMode;
    logic       oCursor;
    logic       oStartPulse;
    logic       oAbortPulse;

    int total = 0;
    int bad = 0;

    // Model state: mode number, cursor, last sampled key levels, result entry step index.
    int m_mode = 0;
    int m_cursor = 0;
    int m_start = 0;
    int m_abort = 0;
    int m_entry = 0;
    int step_no = 0;
    bit last_key [4] = '{0, 0, 0, 0};

    game_mode_fsm #(.RESULT_CYCLES(8), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .iKeyUp(iKeyUp), .iKeyDown(iKeyDown),
        .iKeySelect(iKeySelect), .iKeyBack(iKeyBack),
        .iGameDone(iGameDone),
        .oGameMode(oGameMode), .oCursor(oCursor),
        .oStartPulse(oStartPulse), .oAbortPulse(oAbortPulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic check_all();
        chk("mode",   int'(oGameMode),   m_mode);
        chk("cursor", int'(oCursor),     m_cursor);
        chk("start",  int'(oStartPulse), m_start);
        chk("abort",  int'(oAbortPulse), m_abort);
    endtask

    // Apply one clock of inputs (called at a falling edge), predict, then compare at next falling edge.
    task automatic step(input bit up, input bit dn, input bit sel, input bit bk, input bit done);
        bit now_key [4];
        bit pressed [4];
        iKeyUp = up; iKeyDown = dn; iKeySelect = sel; iKeyBack = bk; iGameDone = done;
        now_key = '{up, dn, sel, bk};
        for (int k = 0; k < 4; k++) begin
            pressed[k] = now_key[k] && !last_key[k];
            last_key[k] = now_key[k];
        end
        step_no++;
        m_start = 0;
        m_abort = 0;
        if (m_mode == 0) begin
            if (pressed[2]) begin
                m_mode = 1 + m_cursor;
                m_start = 1;
            end else if (pressed[0] != pressed[1]) begin
                m_cursor = 1 - m_cursor;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            if (pressed[3]) begin
                m_mode = 0;
                m_abort = 1;
            end else if (done) begin
                m_mode = 3;
                m_entry = step_no;
            end
        end else begin
            if (pressed[2] || pressed[3] || (step_no - m_entry >= 8)) m_mode = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input int hold_cycles);
        #2 resetn = 1'b0;
        #1;
        m_mode = 0; m_cursor = 0; m_start = 0; m_abort = 0;
        last_key = '{0, 0, 0, 0};
        check_all();
        repeat (hold_cycles) @(negedge clk);
        check_all();
        resetn = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        check_all();
        @(negedge clk);
        resetn = 1'b1;

        // Down then Select lands in chimp with a single start pulse.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("chimp_entry_mode", int'(oGameMode), 2);
        // Back and done together: abort wins.
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        // Cursor back to 0, hold Select 20 cycles, then game done.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("result_mode", int'(oGameMode), 3);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        chk("result_timeout", int'(oGameMode), 0);
        // Up and Down together, then Up alone wraps.
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Reset four cycles into a result screen.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        pulse_reset(2);
        // Select held through reset release counts as a press.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);

        // Random phase with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit u, d, s, b, g;
            u = iKeyUp     ^ ($urandom_range(0, 3) == 0);
            d = iKeyDown   ^ ($urandom_range(0, 3) == 0);
            s = iKeySelect ^ ($urandom_range(0, 5) == 0);
            b = iKeyBack   ^ ($urandom_range(0, 11) == 0);
            g = ($urandom_range(0, 9) == 0);
            step(u, d, s, b, g);
            if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_mode_fsm.md
GAME_MODE_FSM -- requirements
Module: game_mode_fsm

Interface
REQ-001 SHALL have parameter: RESULT_CYCLES, 50_000_000, clk cycles the result screen is held (1 s at 50 MHz).
REQ-002 SHALL have parameter: CNT_W, 26, result counter width; SHALL satisfy 2^CNT_W >= RESULT_CYCLES.
REQ-003 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: iKeyUp  in  1  menu cursor up; level, synchronized and debounced upstream, active-high.
REQ-006 SHALL have port: iKeyDown  in  1  menu cursor down; same properties as iKeyUp.
REQ-007 SHALL have port: iKeySelect  in  1  start the highlighted game, or leave the result screen.
REQ-008 SHALL have port: iKeyBack  in  1  abort the current game or result screen.
REQ-009 SHALL have port: iGameDone  in  1  one-cycle pulse from the active game on completion.
REQ-010 SHALL have port: oGameMode  out  2  0=menu, 1=reaction, 2=chimp, 3=result; registered; feeds the VGA enable decoder.
REQ-011 SHALL have port: oCursor  out  1  highlighted menu entry: 0=reaction, 1=chimp.
REQ-012 SHALL have port: oStartPulse  out  1  one-cycle pulse when entering a game.
REQ-013 SHALL have port: oAbortPulse  out  1  one-cycle pulse when a game is left through Back.

Function
REQ-014 SHALL act on key presses only: a press is the key sampled 1 after being sampled 0 on the previous edge; a held key SHALL NOT repeat.
REQ-015 SHALL apply a press on the same clock edge that samples it; outputs reflect it immediately after that edge.
REQ-016 SHALL implement states MENU, REACTION, CHIMP and RESULT, with oGameMode equal to the state encoding.
REQ-017 In MENU, Up or Down press SHALL toggle oCursor; the cursor SHALL wrap across the two entries.
REQ-018 In MENU, Up and Down pressed in the same cycle SHALL leave oCursor unchanged.
REQ-019 In MENU, Select SHALL go to REACTION (oCursor=0) or CHIMP (oCursor=1) and SHALL assert oStartPulse for exactly that cycle.
REQ-020 Priority within one cycle SHALL be Back > Select > Up/Down.
REQ-021 In MENU, Back and iGameDone SHALL be ignored.
REQ-022 In REACTION/CHIMP, iGameDone SHALL go to RESULT and clear the result counter.
REQ-023 In REACTION/CHIMP, Back SHALL go to MENU and pulse oAbortPulse.
REQ-024 In REACTION/CHIMP, Back with iGameDone in the same cycle SHALL resolve as Back: MENU, abort pulse, no RESULT.
REQ-025 In REACTION/CHIMP, Up/Down/Select SHALL be ignored and oCursor SHALL be frozen.
REQ-026 In RESULT, the counter SHALL increment every cycle; at RESULT_CYCLES-1 the next edge SHALL go to MENU.
REQ-027 In RESULT, Select or Back SHALL return to MENU early; oAbortPulse SHALL NOT assert on leaving RESULT.
REQ-028 In RESULT, iGameDone SHALL be ignored.
REQ-029 oCursor SHALL be retained across game/result cycles, so MENU reappears with the previous highlight.
REQ-030 oStartPulse and oAbortPulse SHALL never be asserted in the same cycle.
REQ-031 oStartPulse and oAbortPulse SHALL never be high for two consecutive cycles.
REQ-032 oGameMode SHALL never change other than by REQ-019, REQ-022/023, REQ-026/027 or reset.

Reset
REQ-033 Asserting resetn low SHALL immediately force state MENU, oGameMode=0 and oCursor=0.
REQ-034 Reset SHALL immediately force oStartPulse=0, oAbortPulse=0, the counter to 0 and all key-history registers to 0.
REQ-035 Reset mid-game or mid-result SHALL abandon it with no pulse on any output.
REQ-036 A key already held when resetn releases SHALL count as a press on the first sampled edge.

Structure
REQ-037 Mode encodings (MODE_MENU=0, MODE_REACTION=1, MODE_CHIMP=2, MODE_RESULT=3) SHALL live in the shared game package used by this block and the VGA enable decoder.
REQ-038 Rising-edge press detection SHALL be one sub-module, key_press_detect, instantiated once per key (4 instances); all other logic stays in game_mode_fsm.

Verification (RESULT_CYCLES=8 for simulation)
REQ-039 Reset, Down press, then Select press -> oCursor=1, oGameMode=2, oStartPulse high exactly one cycle.
REQ-040 Select held 20 cycles in MENU with oCursor=0 -> single transition to mode 1, one oStartPulse; release then iGameDone -> mode 3.
REQ-041 Mode 3 with no keys -> mode 0 exactly 8 cycles after entry; oCursor unchanged.
REQ-042 In mode 2, iGameDone and Back in the same cycle -> mode 0, oAbortPulse one cycle, mode 3 never seen.
REQ-043 In MENU, Up and Down pressed together -> oCursor unchanged; Up alone at oCursor=0 -> oCursor=1 (wrap).
REQ-044 resetn pulled low mid-RESULT at count 4 -> immediate mode 0, oCursor=0, no pulses; after release, normal operation with a fresh counter.
